aes_axis_host: RTL and testbench
================================

Name: aes_axis_host

Overview:
- AXI-Stream initiator for the AES accelerator wrapper: the accelerator's other end, acting as the host/test-harness driver and in-fabric client.
- Holds up to 2^BUF_ADDR_WIDTH 128-bit input blocks loaded by local logic.
- On start, transmits one command word followed by blk_cnt*4 payload words on the master stream.
- Then collects blk_cnt*4 result words from the slave stream into a result buffer for local readback.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, master stream width; only 32 supported.
- C_S_AXIS_TDATA_WIDTH, 32, slave stream width; only 32 supported.
- BUF_ADDR_WIDTH, 4, log2 of input and result buffer depth in 128-bit blocks.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- cmd  in  32  command word; sampled on accepted start.
- blk_cnt  in  BUF_ADDR_WIDTH+1  blocks to send; sampled on accepted start.
- busy  out  1  high from accepted start until the DONE cycle, inclusive.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  status for the last run; valid with done, held until the next accepted start.
- in_w_e  in  1  input buffer write enable.
- in_addr  in  BUF_ADDR_WIDTH  input buffer write address.
- in_data  in  128  input block.
- out_r_addr  in  BUF_ADDR_WIDTH  result buffer read address.
- out_r_data  out  128  result block; 1-cycle registered read.
- m00_axis_tvalid/tdata[32]/tstrb[4]/tlast  out, m00_axis_tready  in  command+payload stream.
- s00_axis_tvalid/tdata[32]/tstrb[4]/tlast  in, s00_axis_tready  out  result stream.

Behaviour:
- Reset: async assert, sync deassert internally. All outputs 0: busy, done, err, tvalid, tlast, tdata, tready, out_r_data. FSM to IDLE; counters to 0. Buffer contents undefined.
- Reset mid-transfer: abandons the transfer immediately with no tlast emitted. Downstream must also be reset.
- FSM IDLE -> SEND_CMD -> SEND_PAYLOAD -> RECV -> DONE -> IDLE.
- IDLE, start=1:
  - If blk_cnt==0 or blk_cnt>2^BUF_ADDR_WIDTH: go to DONE with err=1; no stream traffic.
  - Otherwise latch cmd and blk_cnt, clear err, go to SEND_CMD.
- SEND_CMD: tvalid=1, tdata=cmd, tlast=0. On tvalid&tready go to SEND_PAYLOAD.
- SEND_PAYLOAD:
  - Word order: block 0 first; within a block, most-significant word first (bits 127:96 down to 31:0).
  - tlast=1 only on word 3 of block blk_cnt-1.
  - Word counter is 2 bits; block counter is BUF_ADDR_WIDTH+1 bits.
  - On the final handshake go to RECV.
- Master rules:
  - tvalid has no combinational dependence on tready.
  - Once tvalid is high, tdata/tlast stay stable until the handshake.
  - tvalid is never dropped without a handshake.
  - tstrb is constant all-ones.
  - Zero bubble cycles between consecutive words while tready=1.
- RECV:
  - s00_axis_tready=1 only in RECV.
  - Words are shifted into a 128-bit assembly register MSW-first. After the 4th word, the register is written to result buffer index rx_blk.
  - Ends after exactly blk_cnt*4 handshakes; tready drops the cycle after the final handshake.
  - err is set if tlast=1 on any non-final word, or tlast=0 on the final word.
  - Receive always completes the full count; no early exit on tlast.
  - s00_axis_tstrb is ignored.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Buffer ports:
  - in_w_e while busy=1 is ignored; the write is dropped.
  - Result buffer reads are allowed any time. Reading a block while it is being written returns old or new data with no glitch.
- start while busy: ignored, with no effect on the latched cmd or blk_cnt.

Test Plan:
- Single block: load blk0=0x00112233_44556677_8899aabb_ccddeeff, cmd=0x00000020, blk_cnt=1, tready=1. Required m00 stream: 0x00000020, 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff, tlast on the 5th word only. With an echo model returning the same 4 words + tlast, expect done after the 4th receive handshake, err=0, and out_r_data at addr0 equal to blk0.
- Max blocks: blk_cnt=16 with random m00_axis_tready/s00_axis_tvalid stalls. Require 65 master words, tlast on word 65, tdata stable during stalls, all 16 result blocks matching the model, err=0.
- Protocol errors: echo model drops tlast on the final word -> err=1. Separate run with tlast on word 2 -> err=1, with all 4 words still stored.
- Bad count: blk_cnt=0 and blk_cnt=17 -> done within 2 cycles, err=1, m00_axis_tvalid stays 0.
- Ignored inputs: start and in_w_e pulsed during SEND_PAYLOAD -> no restart and input buffer unchanged; busy/done timing identical to an unperturbed run.
- Async reset: assert axis_aresetn=0 mid-payload, between clock edges -> tvalid, busy and tready drop immediately. After release, a new single-block run completes correctly.

Source files
------------

// File: rtl/aes_axis_host.sv
// AXI-Stream host for the AES accelerator wrapper. Local logic loads 128-bit
// input blocks. On start, the block sends a command word and the payload
// words on m00, then collects the same number of result words from s00.
module aes_axis_host #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BUF_ADDR_WIDTH       = 4
) (
  input  logic                                axis_aclk,
  input  logic                                axis_aresetn,
  // Control
  input  logic                                start,
  input  logic [31:0]                         cmd,
  input  logic [BUF_ADDR_WIDTH:0]             blk_cnt,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  // Local buffers
  input  logic                                in_w_e,
  input  logic [BUF_ADDR_WIDTH-1:0]           in_addr,
  input  logic [127:0]                        in_data,
  input  logic [BUF_ADDR_WIDTH-1:0]           out_r_addr,
  output logic [127:0]                        out_r_data,
  // Command + payload stream
  output logic                                m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  // Result stream
  input  logic                                s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready
);

  localparam int unsigned Depth = 1 << BUF_ADDR_WIDTH;
  localparam logic [BUF_ADDR_WIDTH:0] OneBlk = {{BUF_ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StSendCmd,
    StSendPayload,
    StRecv,
    StDone
  } state_e;

  state_e                  r_state, w_state_d;
  logic [1:0]              r_rst_sync;
  logic                    w_rst_n;
  logic [31:0]             r_cmd;
  logic [BUF_ADDR_WIDTH:0] r_blk_cnt;
  logic [BUF_ADDR_WIDTH:0] r_blk;
  logic [1:0]              r_word;
  logic [95:0]             r_asm;
  logic                    r_err;
  logic [127:0]            r_in_mem  [Depth];
  logic [127:0]            r_out_mem [Depth];
  logic [127:0]            r_out_r_data;

  logic                    w_cnt_ok;
  logic                    w_blk_is_last;
  logic                    w_m_hs;
  logic                    w_s_hs;
  logic                    w_m_last;
  logic                    w_rx_final;
  logic [127:0]            w_blk_data;
  logic [31:0]             w_pay_word;
  logic                    w_unused_tstrb;

  // tstrb on the result stream carries no information for this host.
  assign w_unused_tstrb = ^s00_axis_tstrb;

  // Reset asserts asynchronously and releases synchronously to axis_aclk.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) r_rst_sync <= 2'b00;
    else               r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_cnt_ok      = (blk_cnt != '0) && (32'(blk_cnt) <= Depth);
  assign w_blk_is_last = (r_blk == (r_blk_cnt - OneBlk));
  assign w_blk_data    = r_in_mem[r_blk[BUF_ADDR_WIDTH-1:0]];
  assign w_m_hs        = m00_axis_tvalid && m00_axis_tready;
  assign w_s_hs        = s00_axis_tvalid && s00_axis_tready;
  assign w_m_last      = (r_state == StSendPayload) && (r_word == 2'd3) && w_blk_is_last;
  assign w_rx_final    = (r_word == 2'd3) && w_blk_is_last;

  // Select the payload word, most-significant word of the block first.
  always_comb begin
    w_pay_word = '0;
    unique case (r_word)
      2'd0:    w_pay_word = w_blk_data[127:96];
      2'd1:    w_pay_word = w_blk_data[95:64];
      2'd2:    w_pay_word = w_blk_data[63:32];
      2'd3:    w_pay_word = w_blk_data[31:0];
      default: w_pay_word = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge axis_aclk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next-state logic and stream/status outputs, all decoded from state only.
  always_comb begin
    w_state_d       = r_state;
    m00_axis_tvalid = 1'b0;
    m00_axis_tdata  = '0;
    m00_axis_tlast  = 1'b0;
    s00_axis_tready = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) w_state_d = w_cnt_ok ? StSendCmd : StDone;
      end
      StSendCmd: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tdata  = r_cmd;
        if (w_m_hs) w_state_d = StSendPayload;
      end
      StSendPayload: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tdata  = w_pay_word;
        m00_axis_tlast  = w_m_last;
        if (w_m_hs && w_m_last) w_state_d = StRecv;
      end
      StRecv: begin
        s00_axis_tready = 1'b1;
        if (w_s_hs && w_rx_final) w_state_d = StDone;
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Run parameters, word/block counters, receive assembly and error status.
  // The counters are shared: they restart at zero between send and receive.
  always_ff @(posedge axis_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cmd     <= '0;
      r_blk_cnt <= '0;
      r_blk     <= '0;
      r_word    <= '0;
      r_asm     <= '0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_cnt_ok) begin
              r_cmd     <= cmd;
              r_blk_cnt <= blk_cnt;
              r_err     <= 1'b0;
              r_blk     <= '0;
              r_word    <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StSendPayload: begin
          if (w_m_hs) begin
            r_word <= r_word + 2'd1;
            if (r_word == 2'd3) r_blk <= w_blk_is_last ? '0 : r_blk + OneBlk;
          end
        end
        StRecv: begin
          if (w_s_hs) begin
            r_asm  <= {r_asm[63:0], s00_axis_tdata};
            r_word <= r_word + 2'd1;
            if (r_word == 2'd3) r_blk <= r_blk + OneBlk;
            if (s00_axis_tlast != w_rx_final) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Input buffer: writes are dropped while a run is in progress.
  always_ff @(posedge axis_aclk) begin
    if (in_w_e && (r_state == StIdle)) r_in_mem[in_addr] <= in_data;
  end

  // Result buffer: store the assembled block on its fourth word.
  always_ff @(posedge axis_aclk) begin
    if ((r_state == StRecv) && w_s_hs && (r_word == 2'd3)) begin
      r_out_mem[r_blk[BUF_ADDR_WIDTH-1:0]] <= {r_asm, s00_axis_tdata};
    end
  end

  // Registered result readback.
  always_ff @(posedge axis_aclk or negedge w_rst_n) begin
    if (!w_rst_n) r_out_r_data <= '0;
    else          r_out_r_data <= r_out_mem[out_r_addr];
  end

  assign out_r_data     = r_out_r_data;
  assign err            = r_err;
  assign m00_axis_tstrb = '1;

endmodule

// File: tb/tb_aes_axis_host.sv
// Directed bench for aes_axis_host: drives both streams from the falling edge
// and echoes captured payload words back on the result stream.
module tb_aes_axis_host;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  cmd = '0;
  logic [4:0]   blk_cnt = '0;
  logic         busy, done, err;
  logic         in_w_e = 1'b0;
  logic [3:0]   in_addr = '0;
  logic [127:0] in_data = '0;
  logic [3:0]   out_r_addr = '0;
  logic [127:0] out_r_data;
  logic         m_tvalid, m_tlast;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb;
  logic         m_tready = 1'b0;
  logic         s_tvalid = 1'b0;
  logic [31:0]  s_tdata = '0;
  logic [3:0]   s_tstrb = 4'hf;
  logic         s_tlast = 1'b0;
  logic         s_tready;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Results of the most recent run.
  logic [32:0]  g_m[$];
  int           g_timeout, g_stall_bad, g_done_wait, g_done_cyc;
  logic         g_err, g_busy_at_done, g_busy_after, g_err_after;
  logic [127:0] exp_blk[16];

  aes_axis_host dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rst_n),
    .start           (start),
    .cmd             (cmd),
    .blk_cnt         (blk_cnt),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .in_w_e          (in_w_e),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .out_r_addr      (out_r_addr),
    .out_r_data      (out_r_data),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic load_block(input logic [3:0] a, input logic [127:0] d);
    in_w_e = 1'b1; in_addr = a; in_data = d;
    @(negedge clk);
    in_w_e = 1'b0;
  endtask

  // One full transaction; tl_mode 0 = correct tlast, 1 = final tlast dropped,
  // 2 = extra tlast on the second word. Called at a falling edge.
  task automatic run(input logic [31:0] c, input logic [4:0] n, input bit rnd,
                     input int tl_mode, input bit perturb);
    int nm, k, budget, t0, total;
    logic pv, pr, pl;
    logic [31:0] pd;
    g_m.delete();
    g_timeout = 0; g_stall_bad = 0;
    total = 4 * int'(n);
    start = 1'b1; cmd = c; blk_cnt = n; t0 = cyc;
    @(negedge clk);
    start = 1'b0; cmd = 32'hdeadbeef; blk_cnt = '0;
    nm = 0; budget = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    while (nm < total + 1 && budget < 3000) begin
      if (perturb && nm == 3) begin
        start = 1'b1; cmd = 32'h0bad0bad; blk_cnt = 5'd2;
        in_w_e = 1'b1; in_addr = 4'd0; in_data = {4{32'hffffffff}};
      end else begin
        start = 1'b0; in_w_e = 1'b0;
      end
      m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) g_stall_bad++;
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      if (m_tvalid && m_tready) begin
        g_m.push_back({m_tlast, m_tdata});
        nm++;
      end
      @(negedge clk);
      budget++;
    end
    start = 1'b0; in_w_e = 1'b0; m_tready = 1'b0;
    if (budget >= 3000) g_timeout = 1;
    k = 0; budget = 0;
    while (k < total && budget < 3000) begin
      s_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata  = (k + 1 < g_m.size()) ? g_m[k+1][31:0] : 32'h0;
      s_tlast  = (k == total - 1) ? (tl_mode != 1) : (tl_mode == 2 && k == 1);
      if (s_tvalid && s_tready) k++;
      @(negedge clk);
      budget++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (budget >= 3000) g_timeout = 1;
    budget = 0;
    while (!done && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    g_done_wait = budget; g_done_cyc = cyc - t0;
    g_err = err; g_busy_at_done = busy;
    @(negedge clk);
    g_busy_after = busy; g_err_after = err;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, done, err, m_tvalid, m_tlast, s_tready} !== 6'b0 || m_tdata !== 32'h0 ||
        out_r_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_in: busy=%b done=%b err=%b tvalid=%b tlast=%b tready=%b tdata=%h rd=%h, want all 0",
               busy, done, err, m_tvalid, m_tlast, s_tready, m_tdata, out_r_data);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({busy, done, err, m_tvalid, s_tready} !== 5'b0 || m_tstrb !== 4'hf) begin
      n_fail++;
      $display("FAIL reset_out: busy=%b done=%b err=%b tvalid=%b tready=%b tstrb=%h, want 0s and tstrb=f",
               busy, done, err, m_tvalid, s_tready, m_tstrb);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_w[5];
    exp_w = '{32'h00000020, 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    load_block(4'd0, 128'h00112233_44556677_8899aabb_ccddeeff);
    run(32'h20, 5'd1, 1'b0, 0, 1'b0);
    n_checks++;
    if (g_timeout != 0 || g_m.size() != 5) begin
      n_fail++;
      $display("FAIL single_count: timeout=%0d words=%0d, want 0 and 5", g_timeout, g_m.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i < g_m.size() && g_m[i] !== {(i == 4), exp_w[i]}) begin
        n_fail++;
        $display("FAIL single_word%0d: got last=%b data=%h, want last=%b data=%h",
                 i, g_m[i][32], g_m[i][31:0], (i == 4), exp_w[i]);
      end
    end
    n_checks++;
    if (g_done_wait != 0 || g_done_cyc != 10 || g_err !== 1'b0 || g_busy_at_done !== 1'b1 ||
        g_busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: wait=%0d cyc=%0d err=%b busy=%b busy_after=%b, want 0 10 0 1 0",
               g_done_wait, g_done_cyc, g_err, g_busy_at_done, g_busy_after);
    end
    out_r_addr = 4'd0;
    @(negedge clk);
    n_checks++;
    if (out_r_data !== 128'h00112233_44556677_8899aabb_ccddeeff) begin
      n_fail++;
      $display("FAIL single_readback: got %h, want 00112233445566778899aabbccddeeff", out_r_data);
    end
  endtask

  task automatic test_max_blocks();
    logic [31:0] w;
    int bad_words, bad_rd;
    for (int b = 0; b < 16; b++) begin
      exp_blk[b] = {32'ha0000000 + 32'(b * 4), 32'hb1000000 + 32'(b * 4 + 1),
                    32'hc2000000 + 32'(b * 4 + 2), 32'hd3000000 + 32'(b * 4 + 3)};
      load_block(b[3:0], exp_blk[b]);
    end
    run(32'h00000123, 5'd16, 1'b1, 0, 1'b0);
    n_checks++;
    if (g_timeout != 0 || g_m.size() != 65) begin
      n_fail++;
      $display("FAIL max_count: timeout=%0d words=%0d, want 0 and 65", g_timeout, g_m.size());
    end
    bad_words = 0;
    for (int i = 0; i < g_m.size(); i++) begin
      w = (i == 0) ? 32'h00000123 : exp_blk[(i - 1) / 4][(3 - (i - 1) % 4) * 32 +: 32];
      if (g_m[i] !== {(i == 64), w}) bad_words++;
    end
    n_checks++;
    if (bad_words != 0) begin
      n_fail++;
      $display("FAIL max_words: %0d wrong words or tlast flags, want 0", bad_words);
    end
    n_checks++;
    if (g_stall_bad != 0 || g_err !== 1'b0 || g_done_wait != 0) begin
      n_fail++;
      $display("FAIL max_status: stall_changes=%0d err=%b done_wait=%0d, want 0 0 0",
               g_stall_bad, g_err, g_done_wait);
    end
    bad_rd = 0;
    for (int b = 0; b < 16; b++) begin
      out_r_addr = b[3:0];
      @(negedge clk);
      if (out_r_data !== exp_blk[b]) bad_rd++;
    end
    n_checks++;
    if (bad_rd != 0) begin
      n_fail++;
      $display("FAIL max_readback: %0d wrong result blocks, want 0", bad_rd);
    end
  endtask

  task automatic test_protocol_errors();
    load_block(4'd0, 128'h01020304_05060708_090a0b0c_0d0e0f10);
    run(32'h7, 5'd1, 1'b0, 1, 1'b0);
    n_checks++;
    if (g_err !== 1'b1 || g_done_wait != 0 || g_err_after !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_no_last: err=%b done_wait=%0d err_held=%b, want 1 0 1",
               g_err, g_done_wait, g_err_after);
    end
    load_block(4'd0, 128'hcafef00d_12345678_9abcdef0_0badbeef);
    run(32'h8, 5'd1, 1'b0, 2, 1'b0);
    n_checks++;
    if (g_err !== 1'b1 || g_done_wait != 0) begin
      n_fail++;
      $display("FAIL proto_early_last: err=%b done_wait=%0d, want 1 0", g_err, g_done_wait);
    end
    out_r_addr = 4'd0;
    @(negedge clk);
    n_checks++;
    if (out_r_data !== 128'hcafef00d_12345678_9abcdef0_0badbeef) begin
      n_fail++;
      $display("FAIL proto_stored: got %h, want cafef00d123456789abcdef00badbeef", out_r_data);
    end
  endtask

  task automatic test_bad_count();
    logic [4:0] cnts[2];
    int done_at;
    bit saw_valid;
    cnts = '{5'd0, 5'd17};
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; blk_cnt = cnts[t]; cmd = 32'h55;
      @(negedge clk);
      start = 1'b0; blk_cnt = '0;
      done_at = -1; saw_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_tvalid) saw_valid = 1'b1;
        if (done && done_at < 0) begin
          done_at = i;
          n_checks++;
          if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_count_err%0d: err=%b, want 1", cnts[t], err);
          end
        end
        @(negedge clk);
      end
      n_checks++;
      if (done_at < 0 || done_at > 1 || saw_valid) begin
        n_fail++;
        $display("FAIL bad_count%0d: done_at=%0d tvalid_seen=%b, want done_at 0..1 and no tvalid",
                 cnts[t], done_at, saw_valid);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [31:0] exp_w[5];
    exp_w = '{32'h00000042, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load_block(4'd0, 128'h11111111_22222222_33333333_44444444);
    run(32'h42, 5'd1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= g_m.size() || g_m[i] !== {(i == 4), exp_w[i]}) begin
        n_fail++;
        $display("FAIL ignored_word%0d: got %h, want last=%b data=%h", i,
                 (i < g_m.size()) ? g_m[i] : 33'h0, (i == 4), exp_w[i]);
      end
    end
    n_checks++;
    if (g_done_cyc != 10 || g_busy_after !== 1'b0 || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_timing: done_cyc=%0d busy_after=%b err=%b, want 10 0 0",
               g_done_cyc, g_busy_after, g_err);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_restart: busy=%b tvalid=%b, want 0 0", busy, m_tvalid);
    end
    // A fresh run without reloading proves the buffer kept its contents.
    run(32'h43, 5'd1, 1'b0, 0, 1'b0);
    n_checks++;
    if (g_m.size() != 5 || g_m[1][31:0] !== 32'h11111111) begin
      n_fail++;
      $display("FAIL ignored_buffer: words=%0d first payload=%h, want 5 and 11111111",
               g_m.size(), (g_m.size() > 1) ? g_m[1][31:0] : 32'h0);
    end
  endtask

  task automatic test_async_reset();
    int nm, budget;
    load_block(4'd0, 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd);
    load_block(4'd1, 128'h10101010_20202020_30303030_40404040);
    start = 1'b1; cmd = 32'h99; blk_cnt = 5'd2;
    @(negedge clk);
    start = 1'b0;
    nm = 0; budget = 0;
    while (nm < 4 && budget < 100) begin
      m_tready = 1'b1;
      if (m_tvalid) nm++;
      @(negedge clk);
      budget++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b0 || m_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: tvalid=%b busy=%b tready=%b tlast=%b, want 0 0 0 0",
               m_tvalid, busy, s_tready, m_tlast);
    end
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    load_block(4'd0, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    run(32'h20, 5'd1, 1'b0, 0, 1'b0);
    n_checks++;
    if (g_timeout != 0 || g_m.size() != 5 || g_m[0] !== {1'b0, 32'h20} ||
        g_m[4] !== {1'b1, 32'h03020100} || g_err !== 1'b0 || g_done_cyc != 10) begin
      n_fail++;
      $display("FAIL async_rerun: words=%0d err=%b done_cyc=%0d, want 5 words, err 0, cyc 10",
               g_m.size(), g_err, g_done_cyc);
    end
    out_r_addr = 4'd0;
    @(negedge clk);
    n_checks++;
    if (out_r_data !== 128'h0f0e0d0c_0b0a0908_07060504_03020100) begin
      n_fail++;
      $display("FAIL async_readback: got %h, want 0f0e0d0c0b0a09080706050403020100", out_r_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max_blocks();
    test_protocol_errors();
    test_bad_count();
    test_ignored_inputs();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
